// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: exception code width, default exception vector,
// MIPS-style ExcCode constants and the exception-merge helper.
package pipe_pkg;

  localparam int EXC_W = 4;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;

  typedef enum logic [EXC_W-1:0] {
    EXC_INT  = 4'd0,
    EXC_ADEL = 4'd4,
    EXC_ADES = 4'd5,
    EXC_RI   = 4'd10,
    EXC_OV   = 4'd12
  } exc_code_e;

  // An exception inherited from an earlier stage always outranks one found here.
  function automatic logic [EXC_W-1:0] merge_exc(input logic [EXC_W-1:0] exc_old,
                                                 input logic [EXC_W-1:0] exc_new);
    logic [EXC_W-1:0] res;
    if (exc_old != 4'd0) begin
      res = exc_old;
    end else begin
      res = exc_new;
    end
    return res;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Ready/valid storage of 1 entry (combinational ready) or 2 entries (registered
// ready, head entry always drives the output). clr empties it synchronously.
module pipe_skid_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data
);

  generate
    if (DEPTH == 1) begin : g_single
      logic [WIDTH-1:0] head_q, head_d;
      logic             head_vld_q, head_vld_d;
      logic             push_s, pop_s;

      assign push_ready = !head_vld_q | pop_ready;
      assign pop_valid  = head_vld_q;
      assign pop_data   = head_q;

      always_comb begin
        head_d     = head_q;
        head_vld_d = head_vld_q;
        push_s     = push_valid & push_ready;
        pop_s      = head_vld_q & pop_ready;
        if (clr) begin
          head_vld_d = 1'b0;
        end else if (push_s) begin
          head_d     = push_data;
          head_vld_d = 1'b1;
        end else if (pop_s) begin
          head_vld_d = 1'b0;
        end else begin
          head_vld_d = head_vld_q;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          head_q     <= {WIDTH{1'b0}};
          head_vld_q <= 1'b0;
        end else begin
          head_q     <= head_d;
          head_vld_q <= head_vld_d;
        end
      end
    end else begin : g_skid
      logic [WIDTH-1:0] head_q, head_d, tail_q, tail_d;
      logic             head_vld_q, head_vld_d, tail_vld_q, tail_vld_d;
      logic             rdy_q, rdy_d;
      logic             push_s, pop_s;

      assign push_ready = rdy_q;
      assign pop_valid  = head_vld_q;
      assign pop_data   = head_q;

      // Tail only fills when the head is stalled; it refills the head on pop.
      always_comb begin
        head_d     = head_q;
        head_vld_d = head_vld_q;
        tail_d     = tail_q;
        tail_vld_d = tail_vld_q;
        push_s     = push_valid & rdy_q;
        pop_s      = head_vld_q & pop_ready;
        if (clr) begin
          head_vld_d = 1'b0;
          tail_vld_d = 1'b0;
        end else if (!head_vld_q) begin
          if (push_s) begin
            head_d     = push_data;
            head_vld_d = 1'b1;
          end else begin
            head_vld_d = 1'b0;
          end
        end else if (!tail_vld_q) begin
          if (push_s && pop_s) begin
            head_d = push_data;
          end else if (push_s) begin
            tail_d     = push_data;
            tail_vld_d = 1'b1;
          end else if (pop_s) begin
            head_vld_d = 1'b0;
          end else begin
            head_vld_d = head_vld_q;
          end
        end else begin
          if (pop_s) begin
            head_d     = tail_q;
            tail_vld_d = 1'b0;
          end else begin
            tail_vld_d = tail_vld_q;
          end
        end
        rdy_d = !(head_vld_d & tail_vld_d);
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          head_q     <= {WIDTH{1'b0}};
          tail_q     <= {WIDTH{1'b0}};
          head_vld_q <= 1'b0;
          tail_vld_q <= 1'b0;
          rdy_q      <= 1'b1;
        end else begin
          head_q     <= head_d;
          tail_q     <= tail_d;
          head_vld_q <= head_vld_d;
          tail_vld_q <= tail_vld_d;
          rdy_q      <= rdy_d;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with flush/exception bubbles that keep EPC/BD valid.
// Define PIPE_STAGE_SKID_EN for a 2-entry skid buffer with registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int          DATA_W     = 136,
  parameter int          PC_W       = 32,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              in_bd,
  input  logic [EXC_W-1:0]  in_exc_old,
  input  logic [EXC_W-1:0]  in_exc_new,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [PC_W-1:0]   out_pc,
  output logic              out_bd,
  output logic [EXC_W-1:0]  out_exc,
  input  logic              flush,
  input  logic              req
);

`ifdef PIPE_STAGE_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  localparam int PAY_W = DATA_W + EXC_W + PC_W + 1;

  logic             live_q;
  logic             kill_s;
  logic             buf_ready_s, buf_valid_s;
  logic [PAY_W-1:0] push_data_s, buf_data_s;
  logic [PC_W-1:0]  bub_pc_q, bub_pc_d;
  logic             bub_bd_q, bub_bd_d;

  assign kill_s      = req | flush;
  assign in_ready    = live_q & buf_ready_s & ~kill_s;
  assign push_data_s = {in_data, merge_exc(in_exc_old, in_exc_new), in_pc, in_bd};

  pipe_skid_buf #(
    .WIDTH(PAY_W),
    .DEPTH(DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (reset),
    .clr       (kill_s),
    .push_valid(in_valid & live_q & ~kill_s),
    .push_ready(buf_ready_s),
    .push_data (push_data_s),
    .pop_valid (buf_valid_s),
    .pop_ready (out_ready),
    .pop_data  (buf_data_s)
  );

  // Bubble PC/BD tracks upstream whenever nothing valid is presented, so an
  // exception taken on a bubble still reports the correct EPC and BD.
  always_comb begin
    bub_pc_d = bub_pc_q;
    bub_bd_d = bub_bd_q;
    if (req) begin
      bub_pc_d = PC_W'(EXC_VECTOR);
      bub_bd_d = 1'b0;
    end else if (flush || !buf_valid_s) begin
      bub_pc_d = in_pc;
      bub_bd_d = in_bd;
    end else begin
      bub_pc_d = bub_pc_q;
      bub_bd_d = bub_bd_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      live_q   <= 1'b0;
      bub_pc_q <= {PC_W{1'b0}};
      bub_bd_q <= 1'b0;
    end else begin
      live_q   <= 1'b1;
      bub_pc_q <= bub_pc_d;
      bub_bd_q <= bub_bd_d;
    end
  end

  always_comb begin
    out_valid = buf_valid_s;
    if (buf_valid_s) begin
      out_data = buf_data_s[PAY_W-1 -: DATA_W];
      out_exc  = buf_data_s[PC_W+EXC_W -: EXC_W];
      out_pc   = buf_data_s[PC_W:1];
      out_bd   = buf_data_s[0];
    end else begin
      out_data = {DATA_W{1'b0}};
      out_exc  = {EXC_W{1'b0}};
      out_pc   = bub_pc_q;
      out_bd   = bub_bd_q;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: driver queues expected beats on
// acceptance, a negedge monitor pops and compares on every output transfer.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [135:0] d;
    logic [31:0]  pc;
    logic         bd;
    logic [3:0]   exc;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready, in_bd, out_valid, out_ready, out_bd, flush, req;
  logic [135:0] in_data, out_data;
  logic [31:0]  in_pc, out_pc;
  logic [3:0]   in_exc_old, in_exc_new, out_exc;

  beat_t sb[$];
  int    tests = 0;
  int    fails = 0;

`ifdef PIPE_STAGE_SKID_EN
  localparam int EXP_ACC = 2;
`else
  localparam int EXP_ACC = 1;
`endif

  pipe_stage_reg dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_pc(in_pc),
    .in_bd(in_bd), .in_exc_old(in_exc_old), .in_exc_new(in_exc_new),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_pc(out_pc), .out_bd(out_bd), .out_exc(out_exc),
    .flush(flush), .req(req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [135:0] act, input logic [135:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic [135:0] d, input logic [31:0] pc, input logic bd,
                        input logic [3:0] eo, input logic [3:0] en);
    in_valid = 1'b1; in_data = d; in_pc = pc; in_bd = bd;
    in_exc_old = eo; in_exc_new = en;
  endtask

  // Drive one beat until accepted; expectation is queued at the acceptance edge.
  task automatic send(input logic [135:0] d, input logic [31:0] pc, input logic bd,
                      input logic [3:0] eo, input logic [3:0] en, input logic [3:0] xe,
                      output int waited);
    beat_t e;
    waited = 0;
    set_in(d, pc, bd, eo, en);
    while (1) begin
      @(negedge clk);
      if (in_ready) begin
        e.d = d; e.pc = pc; e.bd = bd; e.exc = xe;
        sb.push_back(e);
        break;
      end
      waited++;
      if (waited > 50) begin
        tests++; fails++;
        $display("FAIL send_timeout: pc %0h never accepted", pc);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Monitor: compare each delivered beat against the oldest expectation.
  always @(negedge clk) begin
    beat_t e;
    if (!reset) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_beat: got pc %0h expected no output", out_pc);
        end else begin
          e = sb.pop_front();
          chk("mon_data", out_data, e.d);
          chk("mon_pc", {104'd0, out_pc}, {104'd0, e.pc});
          chk("mon_bd", {135'd0, out_bd}, {135'd0, e.bd});
          chk("mon_exc", {132'd0, out_exc}, {132'd0, e.exc});
        end
      end
      if (req || flush) sb.delete();
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]   eo_t[8], en_t[8], ex_t[8];
    logic [135:0] dat;
    logic [31:0]  pc;
    int           w, acc, idx;

    eo_t = '{4'd0, 4'd0, 4'd0, 4'd4, 4'd0, 4'd0, 4'd5, 4'd0};
    en_t = '{4'd4, 4'd0, 4'd10, 4'd12, 4'd0, 4'd0, 4'd0, 4'd12};
    ex_t = '{4'd4, 4'd0, 4'd10, 4'd4, 4'd0, 4'd0, 4'd5, 4'd12};

    reset = 1'b0; in_valid = 1'b0; in_data = 136'd0; in_pc = 32'd0; in_bd = 1'b0;
    in_exc_old = 4'd0; in_exc_new = 4'd0; out_ready = 1'b0; flush = 1'b0; req = 1'b0;
    #1;
    chk("rst_out_valid", {135'd0, out_valid}, 136'd0);
    chk("rst_in_ready", {135'd0, in_ready}, 136'd0);
    chk("rst_out_pc", {104'd0, out_pc}, 136'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    chk("rel_in_ready_before_edge", {135'd0, in_ready}, 136'd0);
    @(posedge clk); #1;
    chk("rel_in_ready_after_edge", {135'd0, in_ready}, 136'd1);

    // Back-to-back stream, latency 1, exception merge vectors.
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      pc  = 32'h0000_3000 + 32'(4 * k);
      dat = {8'h5A, {4{32'hC0DE_0000 + 32'(k)}}};
      send(dat, pc, k[0], eo_t[k], en_t[k], ex_t[k], w);
      chk("stream_no_wait", 136'(w), 136'd0);
      chk("stream_valid", {135'd0, out_valid}, 136'd1);
      chk("stream_pc", {104'd0, out_pc}, {104'd0, pc});
      chk("stream_exc", {132'd0, out_exc}, {132'd0, ex_t[k]});
    end
    @(posedge clk); #1;
    chk("stream_drained", {135'd0, out_valid}, 136'd0);

    // Empty stage: bubble follows upstream PC/BD.
    in_pc = 32'h0000_5550; in_bd = 1'b1;
    @(posedge clk); #1;
    chk("bubble_track_pc", {104'd0, out_pc}, {104'd0, 32'h0000_5550});
    chk("bubble_track_bd", {135'd0, out_bd}, 136'd1);

    // Flush on a full stage.
    out_ready = 1'b0;
    send(136'hF1, 32'h0000_3200, 1'b0, 4'd0, 4'd0, 4'd0, w);
    set_in(136'hF2, 32'h0000_3010, 1'b1, 4'd5, 4'd0);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", {135'd0, in_ready}, 136'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", {135'd0, out_valid}, 136'd0);
    chk("flush_pc", {104'd0, out_pc}, {104'd0, 32'h0000_3010});
    chk("flush_bd", {135'd0, out_bd}, 136'd1);
    chk("flush_exc", {132'd0, out_exc}, 136'd0);
    chk("flush_data", out_data, 136'd0);

    // req together with flush on a full stage.
    send(136'hE1, 32'h0000_3300, 1'b1, 4'd0, 4'd0, 4'd0, w);
    set_in(136'hE2, 32'h0000_3010, 1'b1, 4'd0, 4'd0);
    req = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    req = 1'b0; flush = 1'b0; in_valid = 1'b0;
    chk("req_valid", {135'd0, out_valid}, 136'd0);
    chk("req_pc", {104'd0, out_pc}, {104'd0, 32'h0000_4180});
    chk("req_bd", {135'd0, out_bd}, 136'd0);

    // Backpressure for 3 cycles while pushing, then release.
    acc = 0; idx = 0;
    for (int c = 0; c < 3; c++) begin
      set_in(136'h100 + 136'(idx), 32'h0000_3100 + 32'(4 * idx), 1'b0, 4'd0, 4'd0);
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{d: 136'h100 + 136'(idx), pc: 32'h0000_3100 + 32'(4 * idx),
                       bd: 1'b0, exc: 4'd0});
        acc++; idx++;
      end
      @(posedge clk); #1;
    end
    chk("bp_accepted", 136'(acc), 136'(EXP_ACC));
    chk("bp_in_ready", {135'd0, in_ready}, 136'd0);
    out_ready = 1'b1;
    for (int i = idx; i < 4; i++) begin
      send(136'h100 + 136'(i), 32'h0000_3100 + 32'(4 * i), 1'b0, 4'd0, 4'd0, 4'd0, w);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("bp_drained_valid", {135'd0, out_valid}, 136'd0);
    chk("bp_none_lost", 136'(sb.size()), 136'd0);

    // Reset mid-transfer with a full stage.
    out_ready = 1'b0;
    send(136'hAA, 32'h0000_3400, 1'b1, 4'd12, 4'd0, 4'd12, w);
    set_in(136'hBB, 32'h0000_3404, 1'b1, 4'd0, 4'd0);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_valid", {135'd0, out_valid}, 136'd0);
    chk("mid_rst_in_ready", {135'd0, in_ready}, 136'd0);
    chk("mid_rst_data", out_data, 136'd0);
    chk("mid_rst_pc", {104'd0, out_pc}, 136'd0);
    chk("mid_rst_bd", {135'd0, out_bd}, 136'd0);
    chk("mid_rst_exc", {132'd0, out_exc}, 136'd0);
    @(negedge clk);
    in_valid = 1'b0;
    #1 reset = 1'b1;
    chk("mid_rel_before_edge", {135'd0, in_ready}, 136'd0);
    @(posedge clk); #1;
    chk("mid_rel_in_ready", {135'd0, in_ready}, 136'd1);
    chk("mid_rel_valid", {135'd0, out_valid}, 136'd0);

    chk("sb_empty_at_end", 136'(sb.size()), 136'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 136, width of the stage payload (instr, dest reg, operands, immediate).
REQ-002 SHALL have parameter PC_W, default 32, width of the PC field.
REQ-003 SHALL have parameter EXC_VECTOR, default 32'h0000_4180, the PC presented on an exception-request bubble.
REQ-004 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports in_valid  in  1 / in_ready  out  1  upstream handshake.
REQ-007 SHALL have ports in_data  in  DATA_W / in_pc  in  PC_W / in_bd  in  1  upstream payload, PC, branch-delay flag.
REQ-008 SHALL have ports in_exc_old  in  4 / in_exc_new  in  4  inherited and locally detected exception codes.
REQ-009 SHALL have ports out_valid  out  1 / out_ready  in  1  downstream handshake.
REQ-010 SHALL have ports out_data  out  DATA_W / out_pc  out  PC_W / out_bd  out  1 / out_exc  out  4  registered downstream payload.
REQ-011 SHALL have port flush  in  1  synchronous kill; bubble keeps upstream PC/BD.
REQ-012 SHALL have port req  in  1  synchronous exception/interrupt kill; bubble carries EXC_VECTOR.

Function
REQ-013 SHALL transfer on the input when in_valid & in_ready and on the output when out_valid & out_ready.
REQ-014 SHALL store exc = (in_exc_old != 0) ? in_exc_old : in_exc_new per accepted beat.
REQ-015 SHALL deliver an accepted beat on out_* exactly one cycle after acceptance when empty (latency 1).
REQ-016 SHALL preserve beat order and never drop or duplicate a beat under any out_ready pattern.
REQ-017 SHALL, when empty, drive out_valid=0, out_data=0, out_exc=0, and out_pc/out_bd from a bubble register.
REQ-018 SHALL load the bubble register with in_pc/in_bd on each cycle the stage has no valid output, so EPC/BD remain correct across stalls.
REQ-019 SHALL, on flush, empty all entries, and load the bubble register from in_pc/in_bd of that cycle; no input accepted that cycle.
REQ-020 SHALL, on req, empty all entries and load the bubble register with PC=EXC_VECTOR, BD=0; no input accepted that cycle.
REQ-021 SHALL prioritise reset > req > flush > normal handshake when asserted together.
REQ-022 SHALL, when full with simultaneous pop and push, accept the push and pop in the same cycle with no bubble.
REQ-023 SHALL ignore in_* payload whenever in_valid=0.

Reset
REQ-024 SHALL, while reset=0, immediately force out_valid=0, in_ready=0, out_data=0, out_pc=0, out_bd=0, out_exc=0, all entries empty.
REQ-025 SHALL raise in_ready on the first rising clk edge after reset deasserts; reset mid-transfer discards all beats.

Configuration
REQ-026 SHALL honour macro PIPE_STAGE_SKID_EN: defined -> 2-entry skid buffer, in_ready registered (= not full), no combinational out_ready->in_ready path.
REQ-027 SHALL, without PIPE_STAGE_SKID_EN, hold 1 entry with in_ready = !out_valid | out_ready (combinational), full throughput.

Structure
REQ-028 SHALL take EXC_W=4, default EXC_VECTOR, and ExcCode constants (INT=0, ADEL=4, ADES=5, RI=10, OV=12) from shared package pipe_pkg.
REQ-029 SHALL implement storage in one sub-module pipe_skid_buf (parametrised width, depth 1 or 2); bubble/exception logic stays in pipe_stage_reg.

Verification
REQ-030 Bench SHALL cover: reset low mid-stream -> all outputs 0 at once; in_ready=1 one edge after release.
REQ-031 Bench SHALL cover: 8 beats in_pc=0x3000+4k, out_ready=1 always -> out_pc 0x3000..0x301C one cycle later, no gaps.
REQ-032 Bench SHALL cover: SKID_EN, out_ready=0 for 3 cycles while pushing -> exactly 2 accepted, in_ready=0, none lost after release.
REQ-033 Bench SHALL cover: req with flush, full stage -> out_valid=0, out_pc=0x0000_4180, out_bd=0 next cycle.
REQ-034 Bench SHALL cover: flush with in_pc=0x3010, in_bd=1 -> bubble out_pc=0x3010, out_bd=1, out_exc=0.
REQ-035 Bench SHALL cover: in_exc_old=0 & in_exc_new=10 -> out_exc=10; in_exc_old=4 & in_exc_new=12 -> out_exc=4.
